// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake and multi-cycle unsigned MUL/DIV into {high,low}.
// Build option: define ALU_MUL_EN to include the shift-add multiplier (opcode 6); otherwise opcode 6 is illegal.
module alu_seq #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 start,
    input  logic [4:0]           ALU_Sel,
    input  logic [WORD_SIZE-1:0] A,
    input  logic [WORD_SIZE-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] ALU_low,
    output logic [WORD_SIZE-1:0] ALU_high,
    output logic                 CarryOut,
    output logic                 div_zero,
    output logic                 illegal
);

    localparam int SH_W  = $clog2(WORD_SIZE);
    localparam int CNT_W = $clog2(WORD_SIZE);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_DIV = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
`ifdef ALU_MUL_EN
    localparam logic [4:0] OP_MUL = 5'd6;
`endif
    localparam logic [4:0] OP_SHL = 5'd7;
    localparam logic [4:0] OP_SHR = 5'd8;
    localparam logic [4:0] OP_NEG = 5'd9;
    localparam logic [4:0] OP_NOT = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WORD_SIZE-1:0] low_q;
    logic [WORD_SIZE-1:0] high_q;
    logic                 carry_q;
    logic                 dz_q;
    logic                 ill_q;

    // Iteration working registers: wh_q is partial product / remainder, wl_q multiplier / quotient.
    logic [WORD_SIZE-1:0] wh_q;
    logic [WORD_SIZE-1:0] wl_q;
    logic [WORD_SIZE-1:0] b_q;
`ifdef ALU_MUL_EN
    logic                 is_mul_q;
    logic [WORD_SIZE:0]   mul_sum;
`endif

    logic [WORD_SIZE:0]   sum_ext;
    logic [WORD_SIZE-1:0] sc_low;
    logic [WORD_SIZE-1:0] sc_high;
    logic                 sc_carry;
    logic                 sc_dz;
    logic                 sc_ill;
    logic                 sc_iter;

    logic [WORD_SIZE:0]   div_sh;
    logic [WORD_SIZE-1:0] div_diff;
    logic                 div_ge;
    logic [WORD_SIZE-1:0] step_hi;
    logic [WORD_SIZE-1:0] step_lo;

    logic                 accept;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        sum_ext  = {1'b0, A} + {1'b0, B};
        sc_low   = '0;
        sc_high  = '0;
        sc_carry = 1'b0;
        sc_dz    = 1'b0;
        sc_ill   = 1'b0;
        sc_iter  = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                sc_low   = sum_ext[WORD_SIZE-1:0];
                sc_carry = sum_ext[WORD_SIZE];
            end
            OP_SUB: begin
                sc_low   = A - B;
                sc_carry = (A >= B);
            end
            OP_DIV: begin
                if (B == '0) begin
                    sc_low  = '1;
                    sc_high = A;
                    sc_dz   = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
            OP_AND: sc_low = A & B;
            OP_OR:  sc_low = A | B;
            OP_XOR: sc_low = A ^ B;
`ifdef ALU_MUL_EN
            OP_MUL: sc_iter = 1'b1;
`endif
            OP_SHL: sc_low = A << B[SH_W-1:0];
            OP_SHR: sc_low = A >> B[SH_W-1:0];
            OP_NEG: sc_low = '0 - A;
            OP_NOT: sc_low = ~A;
            default: sc_ill = 1'b1;
        endcase
    end

    // One restoring-divide step; remainder stays below b_q so the difference fits in WORD_SIZE bits.
    always_comb begin
        div_sh   = {wh_q, wl_q[WORD_SIZE-1]};
        div_diff = div_sh[WORD_SIZE-1:0] - b_q;
        div_ge   = (div_sh >= {1'b0, b_q});
        step_hi  = div_ge ? div_diff : div_sh[WORD_SIZE-1:0];
        step_lo  = {wl_q[WORD_SIZE-2:0], div_ge};
`ifdef ALU_MUL_EN
        mul_sum  = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : {(WORD_SIZE+1){1'b0}});
        if (is_mul_q) begin
            step_hi = mul_sum[WORD_SIZE:1];
            step_lo = {mul_sum[0], wl_q[WORD_SIZE-1:1]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wh_q <= '0;
            wl_q <= A;
            b_q  <= B;
`ifdef ALU_MUL_EN
            is_mul_q <= (ALU_Sel == OP_MUL);
`endif
        end else if (state_q == S_ITER) begin
            wh_q <= step_hi;
            wl_q <= step_lo;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            low_q   <= '0;
            high_q  <= '0;
            carry_q <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (sc_iter) begin
                            state_q <= S_ITER;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(WORD_SIZE - 1);
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            low_q   <= sc_low;
                            high_q  <= sc_high;
                            carry_q <= sc_carry;
                            dz_q    <= sc_dz;
                            ill_q   <= sc_ill;
                        end
                    end
                end
                S_ITER: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        low_q   <= step_lo;
                        high_q  <= step_hi;
                        carry_q <= 1'b0;
                        dz_q    <= 1'b0;
                        ill_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ALU_low  = low_q;
    assign ALU_high = high_q;
    assign CarryOut = carry_q;
    assign div_zero = dz_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven bench for alu_seq (WORD_SIZE=32) plus hand-written multi-cycle, busy and reset sequences.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   ALU_Sel = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] ALU_low;
    logic [W-1:0] ALU_high;
    logic         CarryOut;
    logic         div_zero;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WORD_SIZE(W)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .ALU_Sel(ALU_Sel), .A(A), .B(B),
        .busy(busy), .done(done), .ALU_low(ALU_low), .ALU_high(ALU_high),
        .CarryOut(CarryOut), .div_zero(div_zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [4:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c;
        logic         dz;
        logic         ill;
        int           lat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string name, logic [4:0] sel, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] lo, logic [W-1:0] hi, logic c, logic dz, logic ill,
                                int lat);
        vec_t v;
        v.name = name; v.sel = sel; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
        v.c = c; v.dz = dz; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy);
        @(negedge clk);
        ALU_Sel = sel; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic apply(input vec_t v, input int exp_busy);
        int lat, nbusy;
        run_op(v.sel, v.a, v.b, lat, nbusy);
        chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, " busy cycles"}, 64'(nbusy), 64'(exp_busy));
        chk({v.name, " busy in done"}, 64'(busy), 64'(0));
        chk({v.name, " low"}, 64'(ALU_low), 64'(v.lo));
        chk({v.name, " high"}, 64'(ALU_high), 64'(v.hi));
        chk({v.name, " carry"}, 64'(CarryOut), 64'(v.c));
        chk({v.name, " div_zero"}, 64'(div_zero), 64'(v.dz));
        chk({v.name, " illegal"}, 64'(illegal), 64'(v.ill));
        @(negedge clk);
        chk({v.name, " done width"}, 64'(done), 64'(0));
    endtask

    task automatic busy_test(input logic [4:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] lo, input logic [W-1:0] hi);
        int ndone, dcyc;
        logic [W-1:0] dlo, dhi;
        ndone = 0; dcyc = 0; dlo = '0; dhi = '0;
        @(negedge clk);
        ALU_Sel = sel; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                ndone++; dcyc = cyc; dlo = ALU_low; dhi = ALU_high;
            end
            if (cyc == 5) begin
                ALU_Sel = 5'd0; A = 32'd1; B = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("busy-start done count", 64'(ndone), 64'(1));
        chk("busy-start done cycle", 64'(dcyc), 64'(W + 1));
        chk("busy-start low", 64'(dlo), 64'(lo));
        chk("busy-start high", 64'(dhi), 64'(hi));
        chk("busy-start low held", 64'(ALU_low), 64'(lo));
    endtask

    initial begin
        int lat, nbusy, ndone;

        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset low", 64'(ALU_low), 64'(0));
        chk("reset high", 64'(ALU_high), 64'(0));
        chk("reset carry", 64'(CarryOut), 64'(0));
        chk("reset div_zero", 64'(div_zero), 64'(0));
        chk("reset illegal", 64'(illegal), 64'(0));
        clr_n = 1'b1;

        vq.push_back(mk("ADD carry",   5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,  1, 0, 0, 1));
        vq.push_back(mk("ADD plain",   5'd0,  32'h1234,     32'h1,        32'h1235,     32'h0,  0, 0, 0, 1));
        vq.push_back(mk("SUB borrow",  5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 32'h0,  0, 0, 0, 1));
        vq.push_back(mk("SUB ge",      5'd1,  32'd7,        32'd5,        32'd2,        32'h0,  1, 0, 0, 1));
        vq.push_back(mk("SUB equal",   5'd1,  32'd5,        32'd5,        32'd0,        32'h0,  1, 0, 0, 1));
        vq.push_back(mk("AND",         5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,  0, 0, 0, 1));
        vq.push_back(mk("OR",          5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0,  0, 0, 0, 1));
        vq.push_back(mk("XOR",         5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,  0, 0, 0, 1));
        vq.push_back(mk("SHL mod",     5'd7,  32'd1,        32'd35,       32'd8,        32'h0,  0, 0, 0, 1));
        vq.push_back(mk("SHR",         5'd8,  32'h80000000, 32'd4,        32'h08000000, 32'h0,  0, 0, 0, 1));
        vq.push_back(mk("SHR by 32",   5'd8,  32'd1,        32'd32,       32'd1,        32'h0,  0, 0, 0, 1));
        vq.push_back(mk("NEG one",     5'd9,  32'd1,        32'd0,        32'hFFFFFFFF, 32'h0,  0, 0, 0, 1));
        vq.push_back(mk("NEG zero",    5'd9,  32'd0,        32'd9,        32'h0,        32'h0,  0, 0, 0, 1));
        vq.push_back(mk("NOT",         5'd10, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,  0, 0, 0, 1));
        vq.push_back(mk("ADD carry2",  5'd0,  32'h80000000, 32'h80000000, 32'h0,        32'h0,  1, 0, 0, 1));
        vq.push_back(mk("ILL 11",      5'd11, 32'h5,        32'h6,        32'h0,        32'h0,  0, 0, 1, 1));
        vq.push_back(mk("ILL 31",      5'd31, 32'h5,        32'h6,        32'h0,        32'h0,  0, 0, 1, 1));
        vq.push_back(mk("DIV by zero", 5'd2,  32'd100,      32'd0,        32'hFFFFFFFF, 32'd100, 0, 1, 0, 1));
        vq.push_back(mk("ADD clears",  5'd0,  32'd2,        32'd3,        32'd5,        32'h0,  0, 0, 0, 1));

        foreach (vq[i]) apply(vq[i], 0);

        apply(mk("DIV 100/7", 5'd2, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, W + 1), W);
        apply(mk("DIV 7/100", 5'd2, 32'd7, 32'd100, 32'd0, 32'd7, 0, 0, 0, W + 1), W);
        apply(mk("DIV max/1", 5'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, 0, W + 1), W);
`ifdef ALU_MUL_EN
        apply(mk("MUL max", 5'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, W + 1), W);
        apply(mk("MUL 2^32", 5'd6, 32'h10000, 32'h10000, 32'h0, 32'h1, 0, 0, 0, W + 1), W);
        apply(mk("MUL 3x5", 5'd6, 32'd3, 32'd5, 32'd15, 32'd0, 0, 0, 0, W + 1), W);
        busy_test(5'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
`else
        apply(mk("MUL disabled", 5'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 1, 1), 0);
        busy_test(5'd2, 32'd100, 32'd7, 32'd14, 32'd2);
`endif

        // Abort a DIV with an asynchronous reset in its tenth cycle.
        @(negedge clk);
        ALU_Sel = 5'd2; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort busy before reset", 64'(busy), 64'(1));
        clr_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort low", 64'(ALU_low), 64'(0));
        chk("abort high", 64'(ALU_high), 64'(0));
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort no done", 64'(ndone), 64'(0));
        run_op(5'd0, 32'd2, 32'd3, lat, nbusy);
        chk("post-abort latency", 64'(lat), 64'(1));
        chk("post-abort low", 64'(ALU_low), 64'(5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
